frame_sequencer: RTL and testbench
==================================

// Module: frame_sequencer
// PURPOSE
//   Drives the stack-frame register interface that ebp/esp register blocks consume.
//   Executes ENTER (level 0) and LEAVE as multi-cycle sequences.
//   Emits one register write command per cycle on reg_cmd/reg_wdata (4'h1 = esp, 4'h2 = ebp).
//   Performs the single stack push/pop through a req/ack memory port.
//   Sits between instruction decode and the register file.
// PARAMETERS
//   WORD_BYTES   4      stack slot size; push/pop adjust by this amount
//   IMM_W        16     width of ENTER frame-size immediate
// PORTS
//   clock_5     in   1      single clock, all state updates on posedge
//   reset       in   1      asynchronous, active-low
//   op_valid    in   1      op request; accepted when op_valid & op_ready
//   op_code     in   2      2'b01 ENTER, 2'b10 LEAVE, others ignored (no accept)
//   op_imm      in   IMM_W  ENTER frame size in bytes (zero-extended)
//   op_ready    out  1      high only in IDLE
//   esp_in      in   32     current esp, sampled at accept
//   ebp_in      in   32     current ebp, sampled at accept
//   reg_cmd     out  4      4'h0 none, 4'h1 write esp, 4'h2 write ebp
//   reg_wdata   out  32     data for reg_cmd; valid when reg_cmd != 0
//   mem_req     out  1      memory request, held until mem_ack
//   mem_we      out  1      1 write (push), 0 read (pop); valid with mem_req
//   mem_addr    out  32     stack address
//   mem_wdata   out  32     push data
//   mem_rdata   in   32     pop data, valid with mem_ack on a read
//   mem_ack     in   1      completes request in the cycle it is sampled high with mem_req
//   done        out  1      one-cycle pulse after the last command of an op
//   fault       out  1      one-cycle pulse on alignment fault (STACK_ALIGN_CHECK_EN only, else tied 0)
// BEHAVIOUR
//   Reset: state IDLE; op_ready=1; reg_cmd=0; reg_wdata=0; mem_req=0; mem_we=0.
//   Reset (cont.): mem_addr=0; mem_wdata=0; done=0; fault=0.
//   Reset mid-op aborts immediately; no partial command is completed.
//   Accept: snapshot esp_in as S, ebp_in as B, op_imm as N; all sequence data derives from snapshots.
//   ENTER states: IDLE -> E_PUSH -> E_SETESP -> E_SETEBP -> E_SUBESP -> DONE -> IDLE.
//     E_PUSH: mem_req=1, mem_we=1, addr=S-WORD_BYTES, wdata=B; hold until mem_ack.
//     E_SETESP: reg_cmd=1, wdata=S-WORD_BYTES.
//     E_SETEBP: reg_cmd=2, wdata=S-WORD_BYTES.
//     E_SUBESP: reg_cmd=1, wdata=S-WORD_BYTES-N.
//   LEAVE states: IDLE -> L_SETESP -> L_POP -> L_SETEBP -> L_INCESP -> DONE -> IDLE.
//     L_SETESP: reg_cmd=1, wdata=B.
//     L_POP: mem_req=1, mem_we=0, addr=B; on mem_ack latch mem_rdata as P.
//     L_SETEBP: reg_cmd=2, wdata=P.
//     L_INCESP: reg_cmd=1, wdata=B+WORD_BYTES.
//   Each command state lasts exactly one cycle.
//   With zero-wait ack: ENTER is 5 cycles accept->done pulse; LEAVE is 5 cycles.
//   DONE: done=1 for one cycle; op_ready returns the following cycle.
//   Arithmetic: 32-bit modulo 2^32; underflow/overflow wraps silently.
//   N=0 is legal: E_SUBESP still issued with wdata=S-WORD_BYTES.
//   mem_ack while mem_req=0 is ignored; op_valid while busy is ignored.
//   mem_req deasserts the cycle after mem_ack.
//   reg_cmd=0 in every state other than the four command states.
// CONFIGURATION
//   STACK_ALIGN_CHECK_EN defined: at accept, checks S (ENTER) or B (LEAVE) for WORD_BYTES alignment.
//     If misaligned: fault=1 for one cycle; no reg_cmd or mem_req issued; return to IDLE; done stays 0.
//   STACK_ALIGN_CHECK_EN undefined: no check; fault tied 0; misaligned addresses used as-is.
// TESTING
//   ENTER esp=0x1000 ebp=0x2000 imm=0x10, ack at once -> write 0x0FFC<-0x2000; esp=0x0FFC.
//     (cont.) ebp=0x0FFC; esp=0x0FEC; done pulse.
//   LEAVE ebp=0x0FFC, mem[0x0FFC]=0x2000 -> esp=0x0FFC, read 0x0FFC, ebp=0x2000, esp=0x1000, done.
//   ENTER with mem_ack delayed 3 cycles -> mem_req/addr/wdata stable 4 cycles; no reg_cmd until ack.
//   ENTER esp=0x0 imm=0x4 -> push addr 0xFFFFFFFC; final esp 0xFFFFFFF8 (wrap).
//   reset low during L_POP -> mem_req=0 and reg_cmd=0 same cycle.
//     (cont.) After release: op_ready=1; new LEAVE runs normally.
//   STACK_ALIGN_CHECK_EN, ENTER esp=0x1002 -> fault pulse; no mem_req; no reg_cmd; done=0.

Source files
------------

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - ENTER(level 0)/LEAVE stack-frame sequencer; optional STACK_ALIGN_CHECK_EN alignment fault
`timescale 1ns/1ps

module frame_sequencer #(
    parameter int WORD_BYTES = 4,
    parameter int IMM_W      = 16
) (
    input  logic             clock_5,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic [IMM_W-1:0] op_imm,
    output logic             op_ready,
    input  logic [31:0]      esp_in,
    input  logic [31:0]      ebp_in,
    output logic [3:0]       reg_cmd,
    output logic [31:0]      reg_wdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    output logic             done,
    output logic             fault
);

    typedef enum logic [3:0] {
        IDLE,
        E_PUSH,
        E_SETESP,
        E_SETEBP,
        E_SUBESP,
        L_SETESP,
        L_POP,
        L_SETEBP,
        L_INCESP,
        DONE,
        FAULT
    } state_t;

    localparam logic [31:0] WB       = 32'(WORD_BYTES);
    localparam logic [1:0]  OP_ENTER = 2'b01;
    localparam logic [1:0]  OP_LEAVE = 2'b10;
    localparam logic [3:0]  CMD_NONE = 4'h0;
    localparam logic [3:0]  CMD_ESP  = 4'h1;
    localparam logic [3:0]  CMD_EBP  = 4'h2;

    state_t      state_q, state_d;
    logic [31:0] s_q, b_q, p_q;
    logic [IMM_W-1:0] n_q;
    logic        accept_enter, accept_leave, misaligned;
    logic [31:0] new_frame;

    assign accept_enter = (state_q == IDLE) && op_valid && (op_code == OP_ENTER);
    assign accept_leave = (state_q == IDLE) && op_valid && (op_code == OP_LEAVE);
    assign new_frame    = s_q - WB;

`ifdef STACK_ALIGN_CHECK_EN
    assign misaligned = accept_leave ? ((ebp_in % WB) != 32'd0)
                                     : ((esp_in % WB) != 32'd0);
`else
    assign misaligned = 1'b0;
`endif

    // Sequence data comes only from the accept-time snapshots so the
    // register file may change underneath an op without affecting it.
    always_ff @(posedge clock_5 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept_enter || accept_leave) begin
                s_q <= esp_in;
                b_q <= ebp_in;
                n_q <= op_imm;
            end
            if (state_q == L_POP && mem_ack) begin
                p_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        op_ready  = 1'b0;
        reg_cmd   = CMD_NONE;
        reg_wdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        fault     = 1'b0;
        case (state_q)
            IDLE: begin
                op_ready = 1'b1;
                if (accept_enter || accept_leave) begin
                    if (misaligned)        state_d = FAULT;
                    else if (accept_enter) state_d = E_PUSH;
                    else                   state_d = L_SETESP;
                end
            end
            E_PUSH: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = new_frame;
                mem_wdata = b_q;
                if (mem_ack) state_d = E_SETESP;
            end
            E_SETESP: begin
                reg_cmd   = CMD_ESP;
                reg_wdata = new_frame;
                state_d   = E_SETEBP;
            end
            E_SETEBP: begin
                reg_cmd   = CMD_EBP;
                reg_wdata = new_frame;
                state_d   = E_SUBESP;
            end
            E_SUBESP: begin
                reg_cmd   = CMD_ESP;
                reg_wdata = new_frame - 32'(n_q);
                state_d   = DONE;
            end
            L_SETESP: begin
                reg_cmd   = CMD_ESP;
                reg_wdata = b_q;
                state_d   = L_POP;
            end
            L_POP: begin
                mem_req  = 1'b1;
                mem_addr = b_q;
                if (mem_ack) state_d = L_SETEBP;
            end
            L_SETEBP: begin
                reg_cmd   = CMD_EBP;
                reg_wdata = p_q;
                state_d   = L_INCESP;
            end
            L_INCESP: begin
                reg_cmd   = CMD_ESP;
                reg_wdata = b_q + WB;
                state_d   = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            FAULT: begin
`ifdef STACK_ALIGN_CHECK_EN
                fault = 1'b1;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - table, corner-case and randomized model checks for frame_sequencer
`timescale 1ns/1ps

module tb_frame_sequencer;

    localparam logic [31:0] W = 32'd4;

    logic        clock_5 = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic [15:0] op_imm = '0;
    logic        op_ready;
    logic [31:0] esp_in = '0, ebp_in = '0;
    logic [3:0]  reg_cmd;
    logic [31:0] reg_wdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        done, fault;

    frame_sequencer #(.WORD_BYTES(4), .IMM_W(16)) dut (
        .clock_5(clock_5), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .op_imm(op_imm), .op_ready(op_ready), .esp_in(esp_in), .ebp_in(ebp_in),
        .reg_cmd(reg_cmd), .reg_wdata(reg_wdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .done(done), .fault(fault)
    );

    always #5 clock_5 = ~clock_5;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] reg_esp = '0, reg_ebp = '0;
    logic        stray_en = 1'b0;

    int          o_done_cyc, o_req_cycles, o_ncmd;
    logic        o_fault, o_mem_we, o_unstable, o_overlap, o_busy_ready;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_cmd [3];
    logic [31:0] o_dat [3];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem_m.exists(a) ? mem_m[a] : 32'h0;
    endfunction

    function automatic logic exp_fault_f(input logic [1:0] code, input logic [31:0] s, input logic [31:0] b);
`ifdef STACK_ALIGN_CHECK_EN
        return (code == 2'b01) ? (s[1:0] != 2'b00) : (b[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // Starts and ends just after a falling edge; behaves as register file and memory.
    task automatic run_op(input logic [1:0] code, input logic [31:0] esp, input logic [31:0] ebp,
                          input logic [15:0] imm, input int delay);
        chk("ready_before", 32'(op_ready), 32'd1);
        o_done_cyc = 0; o_req_cycles = 0; o_ncmd = 0;
        o_fault = 0; o_mem_we = 0; o_unstable = 0; o_overlap = 0; o_busy_ready = 0;
        o_addr = '0; o_wdata = '0; o_rdata = '0;
        for (int i = 0; i < 3; i++) begin o_cmd[i] = '0; o_dat[i] = '0; end
        mem_ack = 1'b0;
        op_valid = 1'b1; op_code = code; esp_in = esp; ebp_in = ebp; op_imm = imm;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clock_5);
            if (fault) o_fault = 1'b1;
            if (op_ready) o_busy_ready = 1'b1;
            if (reg_cmd != 4'h0) begin
                if (o_ncmd < 3) begin o_cmd[o_ncmd] = reg_cmd; o_dat[o_ncmd] = reg_wdata; end
                o_ncmd++;
                if (reg_cmd == 4'h1) reg_esp = reg_wdata;
                if (reg_cmd == 4'h2) reg_ebp = reg_wdata;
                if (mem_req) o_overlap = 1'b1;
            end
            if (mem_req) begin
                if (o_req_cycles == 0) begin
                    o_addr = mem_addr; o_mem_we = mem_we; o_wdata = mem_wdata;
                end else if (o_addr !== mem_addr || o_mem_we !== mem_we || o_wdata !== mem_wdata) begin
                    o_unstable = 1'b1;
                end
                o_req_cycles++;
                if (o_req_cycles > delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem_m[mem_addr] = mem_wdata;
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = mem_read(mem_addr);
                        o_rdata = mem_rdata;
                    end
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                mem_ack = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata = $urandom;
            end
            if (done) o_done_cyc = cyc;
            if (done || fault) break;
            op_valid = 1'($urandom_range(0, 1));
            op_code = 2'($urandom); esp_in = $urandom; ebp_in = $urandom; op_imm = 16'($urandom);
        end
        op_valid = 1'b0;
        @(negedge clock_5);
        mem_ack = 1'b0;
        chk("ready_after", 32'(op_ready), 32'd1);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("fault_one_cycle", 32'(fault), 32'd0);
        chk("req_after", 32'(mem_req), 32'd0);
    endtask

    task automatic check_common(input logic [1:0] code, input int delay, input logic xf);
        chk("fault_seen", 32'(o_fault), 32'(xf));
        if (xf) begin
            chk("fault_ncmd", 32'(o_ncmd), 32'd0);
            chk("fault_req", 32'(o_req_cycles), 32'd0);
            chk("fault_done", 32'(o_done_cyc), 32'd0);
        end else begin
            chk("done_latency", 32'(o_done_cyc), 32'(5 + delay));
            chk("req_cycles", 32'(o_req_cycles), 32'(delay + 1));
            chk("req_stable", 32'(o_unstable), 32'd0);
            chk("cmd_during_req", 32'(o_overlap), 32'd0);
            chk("ready_while_busy", 32'(o_busy_ready), 32'd0);
            chk("ncmd", 32'(o_ncmd), 32'd3);
            chk("mem_we", 32'(o_mem_we), 32'(code == 2'b01));
        end
    endtask

    // Reference: the architectural effect of ENTER 0 / LEAVE on esp, ebp and the stack.
    task automatic check_model(input logic [1:0] code, input logic [31:0] s, input logic [31:0] b,
                               input logic [15:0] n, input logic [31:0] p);
        logic [3:0]  xc [3];
        logic [31:0] xd [3];
        logic [31:0] frame;
        frame = s - W;
        if (code == 2'b01) begin
            xc[0] = 4'h1; xd[0] = frame;
            xc[1] = 4'h2; xd[1] = frame;
            xc[2] = 4'h1; xd[2] = frame - {16'h0, n};
            chk("push_addr", o_addr, frame);
            chk("push_data", o_wdata, b);
        end else begin
            xc[0] = 4'h1; xd[0] = b;
            xc[1] = 4'h2; xd[1] = p;
            xc[2] = 4'h1; xd[2] = b + W;
            chk("pop_addr", o_addr, b);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("cmd%0d", i), 32'(o_cmd[i]), 32'(xc[i]));
            chk($sformatf("wdata%0d", i), o_dat[i], xd[i]);
        end
        chk("final_esp", reg_esp, xd[2]);
        chk("final_ebp", reg_ebp, xd[1]);
    endtask

    typedef struct {
        logic [1:0]  code;
        logic [31:0] esp, ebp;
        logic [15:0] imm;
        int          delay;
        logic [31:0] x_esp, x_ebp, x_addr, x_mdata;
    } vec_t;

    vec_t vt [7];

    initial begin
        vt[0] = '{2'b01, 32'h1000,     32'h2000,     16'h0010, 0, 32'h0FEC,     32'h0FFC,     32'h0FFC,     32'h2000};
        vt[1] = '{2'b10, 32'h0FEC,     32'h0FFC,     16'h0000, 0, 32'h1000,     32'h2000,     32'h0FFC,     32'h2000};
        vt[2] = '{2'b01, 32'h8000,     32'h9000,     16'h0020, 3, 32'h7FDC,     32'h7FFC,     32'h7FFC,     32'h9000};
        vt[3] = '{2'b01, 32'h0000,     32'h1234,     16'h0004, 0, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h1234};
        vt[4] = '{2'b01, 32'h0100,     32'h0200,     16'h0000, 1, 32'h00FC,     32'h00FC,     32'h00FC,     32'h0200};
        vt[5] = '{2'b10, 32'h0040,     32'hFFFFFFFC, 16'h0000, 2, 32'h0000,     32'h1234,     32'hFFFFFFFC, 32'h1234};
        vt[6] = '{2'b01, 32'h10000,    32'h0005,     16'hFFFF, 0, 32'hFFFFFFFD, 32'h0000FFFC, 32'h0000FFFC, 32'h0005};

        // Reset state
        repeat (2) @(negedge clock_5);
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_cmd", 32'(reg_cmd), 32'd0);
        chk("rst_wdata", reg_wdata, 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_mwdata", mem_wdata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        reset = 1'b1;
        @(negedge clock_5);

        // Unsupported op codes are never accepted
        for (int k = 0; k < 2; k++) begin
            op_valid = 1'b1; op_code = (k == 0) ? 2'b00 : 2'b11; esp_in = 32'h500; ebp_in = 32'h600;
            repeat (3) begin
                @(negedge clock_5);
                chk("ignore_ready", 32'(op_ready), 32'd1);
                chk("ignore_req", 32'(mem_req), 32'd0);
                chk("ignore_cmd", 32'(reg_cmd), 32'd0);
            end
        end
        op_valid = 1'b0;
        @(negedge clock_5);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].code, vt[i].esp, vt[i].ebp, vt[i].imm, vt[i].delay);
            check_common(vt[i].code, vt[i].delay, 1'b0);
            chk($sformatf("t%0d_esp", i), reg_esp, vt[i].x_esp);
            chk($sformatf("t%0d_ebp", i), reg_ebp, vt[i].x_ebp);
            chk($sformatf("t%0d_addr", i), o_addr, vt[i].x_addr);
            chk($sformatf("t%0d_mdata", i), vt[i].code == 2'b01 ? o_wdata : o_rdata, vt[i].x_mdata);
        end

        // Reset asserted while the pop is outstanding
        mem_m[32'h3000] = 32'h0000ABCD;
        mem_ack = 1'b0;
        op_valid = 1'b1; op_code = 2'b10; ebp_in = 32'h3000; esp_in = 32'h2F00;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 10 && seen == 0; c++) begin
                @(negedge clock_5);
                op_valid = 1'b0;
                if (mem_req) seen = 1;
            end
            chk("pop_reached", 32'(seen), 32'd1);
        end
        reset = 1'b0;
        #1;
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_cmd", 32'(reg_cmd), 32'd0);
        chk("abort_ready", 32'(op_ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clock_5);
        reset = 1'b1;
        @(negedge clock_5);
        run_op(2'b10, 32'h2F00, 32'h3000, 16'h0, 1);
        check_common(2'b10, 1, 1'b0);
        check_model(2'b10, 32'h2F00, 32'h3000, 16'h0, 32'h0000ABCD);

`ifdef STACK_ALIGN_CHECK_EN
        run_op(2'b01, 32'h1002, 32'h2000, 16'h10, 0);
        check_common(2'b01, 0, 1'b1);
`endif

        // Randomized ops against the reference
        stray_en = 1'b1;
        for (int r = 0; r < 60; r++) begin
            logic [1:0]  code;
            logic [31:0] s, b, p;
            logic [15:0] n;
            logic        xf;
            int          d;
            code = $urandom_range(0, 1) ? 2'b01 : 2'b10;
            if ($urandom_range(0, 1)) begin
                s = reg_esp; b = reg_ebp;
            end else begin
                s = $urandom; b = $urandom;
                if ($urandom_range(0, 3) != 0) begin s[1:0] = 2'b00; b[1:0] = 2'b00; end
            end
            n = 16'($urandom);
            d = $urandom_range(0, 3);
            if (code == 2'b10 && !mem_m.exists(b)) mem_m[b] = $urandom;
            p = mem_read(b);
            xf = exp_fault_f(code, s, b);
            run_op(code, s, b, n, d);
            check_common(code, d, xf);
            if (!xf) check_model(code, s, b, n, p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
